// File: rtl/spi_slave_rx_if.sv
// ============================================================================
// Module      : spi_slave_rx_if
// Description : Pin and result bundle between an SPI master and spi_slave_rx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_slave_rx_if #(
    parameter int DATA_W = 12
);
    logic              sclk;
    logic              cs;
    logic              mosi;
    logic [DATA_W-1:0] dout;
    logic              done;
    logic              err;
    logic              busy;

    modport slave (
        input  sclk,
        input  cs,
        input  mosi,
        output dout,
        output done,
        output err,
        output busy
    );

    modport master (
        output sclk,
        output cs,
        output mosi,
        input  dout,
        input  done,
        input  err,
        input  busy
    );
endinterface

`default_nettype wire

// File: rtl/spi_slave_rx.sv
// ============================================================================
// Module      : spi_slave_rx
// Description : Oversampling SPI receive end; LSB-first DATA_W-bit words framed
//               by active-low cs, with done/err strobes per frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_rx #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    spi_slave_rx_if.slave     bus
);

    localparam int                 c_CNT_W    = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DATA_W);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers, reset to the idle line levels
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   bus.cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    logic w_sclk;
    logic w_cs;
    logic w_mosi;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_fall;
    logic w_cs_rise;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise =  w_sclk & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk &  r_sclk_prev;
    assign w_cs_fall   = ~w_cs   &  r_cs_prev;
    assign w_cs_rise   =  w_cs   & ~r_cs_prev;

    // ------------------------------------------------------------------
    // Frame state and datapath registers
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0]   r_shreg;
    logic [DATA_W-1:0]   w_shreg_nxt;
    logic                r_ovr;
    logic                w_ovr_nxt;
    logic [DATA_W-1:0]   r_dout;
    logic [DATA_W-1:0]   w_dout_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_err;
    logic                w_err_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_ovr   <= 1'b0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shreg <= w_shreg_nxt;
            r_ovr   <= w_ovr_nxt;
            r_dout  <= w_dout_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shreg_nxt = r_shreg;
        w_ovr_nxt   = r_ovr;
        w_dout_nxt  = r_dout;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = S_ARM;
                    w_cnt_nxt   = '0;
                    w_shreg_nxt = '0;
                    w_ovr_nxt   = 1'b0;
                end
            end

            // Falls seen here precede the first data bit and carry nothing
            S_ARM: begin
                if (w_cs_rise) begin
                    w_state_nxt = S_DONE;
                end else if (w_sclk_rise) begin
                    w_state_nxt = S_SHIFT;
                end
            end

            // A fall coinciding with cs_rise is still sampled before DONE checks the count
            S_SHIFT: begin
                if (w_sclk_fall) begin
                    if (r_cnt < c_CNT_FULL) begin
                        for (int i = 0; i < DATA_W; i++) begin
                            if (r_cnt == c_CNT_W'(i)) begin
                                w_shreg_nxt[i] = w_mosi;
                            end
                        end
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end else begin
                        w_ovr_nxt = 1'b1;
                    end
                end
                if (w_sclk_rise && (r_cnt == c_CNT_FULL)) begin
                    w_ovr_nxt = 1'b1;
                end
                if (w_cs_rise) begin
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                if ((r_cnt == c_CNT_FULL) && !r_ovr) begin
                    w_dout_nxt = r_shreg;
                    w_done_nxt = 1'b1;
                end else begin
                    w_err_nxt  = 1'b1;
                end
                // A new frame may start while the previous one is still being closed
                if (w_cs_fall) begin
                    w_state_nxt = S_ARM;
                    w_cnt_nxt   = '0;
                    w_shreg_nxt = '0;
                    w_ovr_nxt   = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.dout = r_dout;
    assign bus.done = r_done;
    assign bus.err  = r_err;
    assign bus.busy = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
// ============================================================================
// Module      : tb_spi_slave_rx
// Description : Directed self-checking bench for spi_slave_rx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_rx;

    localparam int c_DATA_W = 12;
    localparam int c_HALF   = 110;

    logic clk = 1'b0;
    logic rst = 1'b0;

    spi_slave_rx_if #(.DATA_W(c_DATA_W)) bus ();

    spi_slave_rx #(
        .DATA_W      (c_DATA_W),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Pulse monitor
    int          done_cnt  = 0;
    int          err_cnt   = 0;
    int          busy_cnt  = 0;
    int          viol_cnt  = 0;
    logic        prev_done = 1'b0;
    logic        prev_err  = 1'b0;
    logic [11:0] done_log [0:15];

    always @(negedge clk) begin
        if (bus.done) begin
            if (done_cnt < 16) done_log[done_cnt] = bus.dout;
            done_cnt++;
        end
        if (bus.err)  err_cnt++;
        if (bus.busy) busy_cnt++;
        if ((bus.done && bus.err) || (bus.done && prev_done) || (bus.err && prev_err))
            viol_cnt++;
        prev_done = bus.done;
        prev_err  = bus.err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic frame_start();
        bus.cs = 1'b0;
        #(c_HALF);
    endtask

    task automatic clock_bits(input logic [15:0] data, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            bus.sclk = 1'b1;
            bus.mosi = data[i];
            #(c_HALF);
            bus.sclk = 1'b0;
            #(c_HALF);
        end
    endtask

    task automatic frame_end();
        repeat (3) @(negedge clk);
        bus.cs = 1'b1;
    endtask

    int lat;
    int busy_before;

    initial begin
        bus.sclk = 1'b0;
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
        for (int i = 0; i < 16; i++) done_log[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_dout", {20'd0, bus.dout}, 32'h0);
        check("rst_done", {31'd0, bus.done}, 32'h0);
        check("rst_err",  {31'd0, bus.err},  32'h0);
        check("rst_busy", {31'd0, bus.busy}, 32'h0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // T1 basic word, with cs-rise to done latency
        frame_start();
        clock_bits(16'h0A5C, 12);
        frame_end();
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.done && lat == 0) lat = k;
        end
        check("t1_latency",  lat, 32'd4);
        check("t1_done_cnt", done_cnt, 32'd1);
        check("t1_err_cnt",  err_cnt,  32'd0);
        check("t1_dout",     {20'd0, bus.dout}, 32'h0A5C);
        check("t1_busy_low", {31'd0, bus.busy}, 32'h0);

        // T2 back-to-back with one sclk period of cs high
        frame_start();
        clock_bits(16'h0FFF, 12);
        frame_end();
        repeat (6) @(negedge clk);
        check("t2_first_dout", {20'd0, bus.dout}, 32'h0FFF);
        repeat (16) @(negedge clk);
        frame_start();
        clock_bits(16'h0001, 12);
        frame_end();
        repeat (10) @(negedge clk);
        check("t2_log1",     {20'd0, done_log[1]}, 32'h0FFF);
        check("t2_log2",     {20'd0, done_log[2]}, 32'h0001);
        check("t2_done_cnt", done_cnt, 32'd3);

        // T2b cs high for a single clk: second cs_fall lands in DONE
        frame_start();
        clock_bits(16'h05A3, 12);
        frame_end();
        @(negedge clk);
        frame_start();
        clock_bits(16'h036C, 12);
        frame_end();
        repeat (10) @(negedge clk);
        check("t2b_log3",     {20'd0, done_log[3]}, 32'h05A3);
        check("t2b_log4",     {20'd0, done_log[4]}, 32'h036C);
        check("t2b_done_cnt", done_cnt, 32'd5);
        check("t2b_err_cnt",  err_cnt,  32'd0);

        // T3 short frame
        frame_start();
        clock_bits(16'h001F, 5);
        frame_end();
        repeat (10) @(negedge clk);
        check("t3_err_cnt",  err_cnt,  32'd1);
        check("t3_done_cnt", done_cnt, 32'd5);
        check("t3_dout",     {20'd0, bus.dout}, 32'h036C);

        // T4 long frame
        frame_start();
        clock_bits(16'h3FFF, 14);
        frame_end();
        repeat (10) @(negedge clk);
        check("t4_err_cnt",  err_cnt,  32'd2);
        check("t4_done_cnt", done_cnt, 32'd5);
        check("t4_dout",     {20'd0, bus.dout}, 32'h036C);

        // T5 reset mid-frame, then a clean frame
        frame_start();
        clock_bits(16'h03C3, 7);
        #50;
        rst = 1'b0;
        #20;
        bus.cs   = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        #30;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_abort_done", done_cnt, 32'd5);
        check("t5_abort_err",  err_cnt,  32'd2);
        check("t5_abort_dout", {20'd0, bus.dout}, 32'h0);
        check("t5_abort_busy", {31'd0, bus.busy}, 32'h0);
        frame_start();
        clock_bits(16'h0555, 12);
        frame_end();
        repeat (10) @(negedge clk);
        check("t5_done_cnt", done_cnt, 32'd6);
        check("t5_dout",     {20'd0, bus.dout}, 32'h0555);

        // T6 line noise with cs high
        busy_before = busy_cnt;
        for (int i = 0; i < 20; i++) begin
            bus.sclk = ~bus.sclk;
            bus.mosi = ~bus.mosi;
            #50;
        end
        repeat (10) @(negedge clk);
        check("t6_busy_cycles", busy_cnt - busy_before, 32'd0);
        check("t6_done_cnt",    done_cnt, 32'd6);
        check("t6_err_cnt",     err_cnt,  32'd2);
        check("t6_dout",        {20'd0, bus.dout}, 32'h0555);

        check("pulse_rules", viol_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
